// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per valid/ready handshake, LSB first, idle-high line.
// Latency: tx_pin drops to the start bit one clock after the accepting edge; each bit lasts CYCLE clocks.
// Backpressure: tx_data_ready is high only in S_IDLE; a valid byte offered while busy is ignored.
module uart_tx #(
    parameter int CLK_FRE   = 50,      // system clock in MHz
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0,       // 0 none, 1 odd, 2 even, anything else none
    parameter int STOP_BITS = 1        // 1 or 2, anything else 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_busy,
    output logic       tx_pin
);

    // Clocks per bit; the 16-bit cycle counter limits this to 65535.
    localparam int         CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] CNT_MAX  = 16'(CYCLE - 1);
    localparam bit         PAR_EN    = (PARITY == 1) || (PARITY == 2);
    localparam bit         PAR_ODD   = (PARITY == 1);
    // Index of the final stop bit as tracked in bit_cnt.
    localparam logic [2:0] LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND_BYTE,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        tx_pin_q, tx_pin_d;

    logic        bit_end;
    logic [2:0]  bit_nxt;
    logic        parity_bit;

    assign tx_data_ready = (state_q == S_IDLE);
    assign tx_busy       = (state_q != S_IDLE);
    assign tx_pin        = tx_pin_q;

    // Next-state, counter and next-pin-level logic; the pin itself is only ever a flop output.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        tx_pin_d    = tx_pin_q;
        bit_end     = (cycle_cnt_q == CNT_MAX);
        bit_nxt     = bit_cnt_q + 3'd1;
        parity_bit  = PAR_ODD ? ~^data_q : ^data_q;
        cycle_cnt_d = bit_end ? 16'd0 : cycle_cnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                cycle_cnt_d = 16'd0;
                bit_cnt_d   = 3'd0;
                tx_pin_d    = 1'b1;
                if (tx_data_valid) begin
                    data_d   = tx_data;
                    state_d  = S_START;
                    tx_pin_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_SEND_BYTE;
                    bit_cnt_d = 3'd0;
                    tx_pin_d  = data_q[0];
                end
            end
            S_SEND_BYTE: begin
                if (bit_end) begin
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = bit_nxt;
                        tx_pin_d  = data_q[bit_nxt];
                    end else begin
                        bit_cnt_d = 3'd0;
                        if (PAR_EN) begin
                            state_d  = S_PARITY;
                            tx_pin_d = parity_bit;
                        end else begin
                            state_d  = S_STOP;
                            tx_pin_d = 1'b1;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d  = S_STOP;
                    tx_pin_d = 1'b1;
                end
            end
            S_STOP: begin
                tx_pin_d = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_nxt;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                tx_pin_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset forces the line to mark immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= 16'd0;
            bit_cnt_q   <= 3'd0;
            data_q      <= 8'd0;
            tx_pin_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            tx_pin_q    <= tx_pin_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: six instances with different framing, checked against a frame-level model.
// Latency: expects the start bit on the first clock after acceptance and CYCLE clocks per bit.
// Backpressure: drives valid until ready, optionally holding valid for back-to-back frames.
module tb_uart_tx;

    localparam int N = 6;
    localparam int CYC [N] = '{434, 434, 434, 434, 8, 8};
    localparam int PAR [N] = '{0, 2, 1, 0, 2, 0};
    localparam int STP [N] = '{1, 1, 1, 2, 2, 1};

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] vld;
    logic [7:0]   dat [N];
    wire  [N-1:0] rdy, busy, pin;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx u0 (.clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_data_valid(vld[0]),
                .tx_data_ready(rdy[0]), .tx_busy(busy[0]), .tx_pin(pin[0]));
    uart_tx #(.PARITY(2)) u1 (.clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_data_valid(vld[1]),
                .tx_data_ready(rdy[1]), .tx_busy(busy[1]), .tx_pin(pin[1]));
    uart_tx #(.PARITY(1)) u2 (.clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_data_valid(vld[2]),
                .tx_data_ready(rdy[2]), .tx_busy(busy[2]), .tx_pin(pin[2]));
    uart_tx #(.STOP_BITS(2)) u3 (.clk(clk), .rst_n(rst_n), .tx_data(dat[3]), .tx_data_valid(vld[3]),
                .tx_data_ready(rdy[3]), .tx_busy(busy[3]), .tx_pin(pin[3]));
    uart_tx #(.CLK_FRE(1), .BAUD_RATE(125000), .PARITY(2), .STOP_BITS(2)) u4 (
                .clk(clk), .rst_n(rst_n), .tx_data(dat[4]), .tx_data_valid(vld[4]),
                .tx_data_ready(rdy[4]), .tx_busy(busy[4]), .tx_pin(pin[4]));
    uart_tx #(.CLK_FRE(1), .BAUD_RATE(125000)) u5 (
                .clk(clk), .rst_n(rst_n), .tx_data(dat[5]), .tx_data_valid(vld[5]),
                .tx_data_ready(rdy[5]), .tx_busy(busy[5]), .tx_pin(pin[5]));

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural 8N1 receiver on instance 5: mid-bit sampling, bytes queued in arrival order.
    logic [7:0] rxq [$];
    int rx_ferr = 0;
    initial begin : rx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && pin[5] === 1'b0) begin
                repeat (CYC[5] / 2) @(negedge clk);
                if (pin[5] !== 1'b0) rx_ferr++;
                for (int k = 0; k < 8; k++) begin
                    repeat (CYC[5]) @(negedge clk);
                    b[k] = pin[5];
                end
                repeat (CYC[5]) @(negedge clk);
                if (pin[5] !== 1'b1) rx_ferr++;
                rxq.push_back(b);
            end
        end
    end

    // Sends one byte on instance i and checks every clock of the frame against the model.
    // Entered on a negedge; returns on the negedge where the line should be idle again.
    task automatic send(input int i, input logic [7:0] d, input logic [7:0] mid_d,
                        input bit nxt_v, input logic [7:0] nxt_d, output longint acc_t);
        bit q [$];
        int c, n, t, mis, rdy_bad, busy_bad, ones;
        c = CYC[i];
        q.push_back(1'b0);
        for (int b = 0; b < 8; b++) q.push_back(d[b]);
        ones = $countones(d);
        if (PAR[i] == 2) q.push_back(bit'(ones % 2));
        if (PAR[i] == 1) q.push_back(bit'(1 - ones % 2));
        for (int s = 0; s < STP[i]; s++) q.push_back(1'b1);
        n = q.size();

        dat[i] = d;
        vld[i] = 1'b1;
        t = 0;
        while (rdy[i] !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        acc_t = $time;
        if (rdy[i] !== 1'b1) begin
            chk("accept_timeout", 32'(t), 32'd0);
            vld[i] = 1'b0;
            return;
        end
        mis = 0; rdy_bad = 0; busy_bad = 0;
        for (int k = 0; k <= n * c; k++) begin
            @(negedge clk);
            if (k < n * c) begin
                if (pin[i] !== q[k / c]) mis++;
                if (rdy[i] !== 1'b0) rdy_bad++;
                if (busy[i] !== 1'b1) busy_bad++;
            end
            if (k == 0) vld[i] = nxt_v;
            if (k == 4 * c) dat[i] = mid_d;
            if (k == n * c - 1) dat[i] = nxt_d;
        end
        chk("frame_bad_cycles", 32'(mis), 32'd0);
        chk("rdy_high_in_frame", 32'(rdy_bad), 32'd0);
        chk("busy_low_in_frame", 32'(busy_bad), 32'd0);
        chk("idle_after_frame", {29'd0, rdy[i], busy[i], pin[i]}, 32'b101);
    endtask

    initial begin
        longint t1, t2, td;
        int idle_bad;
        logic [7:0] sent [$];
        logic [7:0] x;

        rst_n = 1'b0;
        vld   = '0;
        for (int i = 0; i < N; i++) dat[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pin", 32'(pin), 32'h3F);
        chk("rst_rdy", 32'(rdy), 32'h3F);
        chk("rst_busy", 32'(busy), 32'h00);
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pin !== 6'h3F || rdy !== 6'h3F || busy !== 6'h00) idle_bad++;
        end
        chk("idle_before_accept", 32'(idle_bad), 32'd0);

        // Default framing, 0x55.
        send(0, 8'h55, 8'($urandom), 1'b0, 8'h00, t1);

        // Back-to-back with valid held; tx_data disturbed mid-frame.
        repeat (5) @(negedge clk);
        send(0, 8'h00, 8'h12, 1'b1, 8'hFF, t1);
        send(0, 8'hFF, 8'h12, 1'b0, 8'h00, t2);
        chk("b2b_gap_8n1", 32'((t2 - t1) / 10), 32'd4341);

        // Reset during data bit 3 of 0xA7 (bit 3 is 0 so the return to mark is visible).
        repeat (3) @(negedge clk);
        dat[0] = 8'hA7;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (4 * 434 + 100) @(negedge clk);
        chk("pre_rst_bit3", 32'(pin[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pin", 32'(pin[0]), 32'd1);
        chk("rst_mid_rdy", 32'(rdy[0]), 32'd1);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (2 * 434) begin
            @(negedge clk);
            if (pin[0] !== 1'b1 || rdy[0] !== 1'b1) idle_bad++;
        end
        chk("no_resume_after_rst", 32'(idle_bad), 32'd0);
        send(0, 8'h3C, 8'($urandom), 1'b0, 8'h00, t1);

        // Parity variants.
        send(1, 8'hA5, 8'($urandom), 1'b0, 8'h00, t1);
        send(2, 8'hA5, 8'($urandom), 1'b0, 8'h00, t1);
        send(1, 8'h01, 8'($urandom), 1'b0, 8'h00, t1);

        // Two stop bits, back-to-back.
        send(3, 8'h80, 8'($urandom), 1'b1, 8'h80, t1);
        send(3, 8'h80, 8'($urandom), 1'b0, 8'h00, t2);
        chk("b2b_gap_8n2", 32'((t2 - t1) / 10), 32'(11 * 434 + 1));

        // Random bytes on the fast 8E2 instance, with occasional back-to-back.
        for (int j = 0; j < 16; j++) begin
            x = 8'($urandom);
            send(4, x, 8'($urandom), 1'b0, 8'h00, t1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Loopback: 256 random bytes on the fast 8N1 instance into the behavioural receiver.
        for (int j = 0; j < 256; j++) begin
            x = 8'($urandom);
            sent.push_back(x);
            send(5, x, 8'($urandom), 1'b0, 8'h00, td);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("rx_count", 32'(rxq.size()), 32'd256);
        chk("rx_framing_errors", 32'(rx_ferr), 32'd0);
        for (int j = 0; j < 256 && j < rxq.size(); j++)
            chk($sformatf("rx_byte_%0d", j), 32'(rxq[j]), 32'(sent[j]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart of the peripheral UART receiver.
- Accepts one byte per valid/ready handshake from the bus/peripheral side.
- Serialises it LSB-first on tx_pin: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Line is idle-high; bit timing is derived from the system clock by an integer cycle count.

Parameters:
- CLK_FRE, 50, system clock frequency in MHz.
- BAUD_RATE, 115200, serial baud rate.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even. Other values are treated as none.
- STOP_BITS, 1, number of stop bits: 1 or 2. Other values are treated as 1.
- Derived localparam CYCLE = CLK_FRE*1000000/BAUD_RATE, integer division. 434 at the defaults.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
- tx_data  input  8  byte to transmit; sampled only on the accepting edge.
- tx_data_valid  input  1  source has a byte on tx_data.
- tx_data_ready  output  1  transmitter can accept a byte; equals (state == S_IDLE).
- tx_busy  output  1  frame in progress; equals (state != S_IDLE).
- tx_pin  output  1  serial output, registered, idle level 1.

Behaviour:
- Reset (async, immediate):
  - state = S_IDLE; tx_pin = 1; cycle_cnt = 0; bit_cnt = 0; shift register = 0.
  - Therefore tx_data_ready = 1 and tx_busy = 0 during and after reset.
  - Reset asserted mid-frame aborts the frame. tx_pin returns to 1 without waiting for a clock edge; no partial byte resumes.
- States: S_IDLE, S_START, S_SEND_BYTE, S_PARITY, S_STOP.
  - Next state is combinational; state, tx_pin and the counters are registered.
- Handshake:
  - A transfer occurs on a rising edge where tx_data_valid && tx_data_ready.
  - On that edge: tx_data is latched into the shift register, state becomes S_START, tx_pin becomes 0, cycle_cnt = 0.
  - tx_data_valid seen while busy is ignored; nothing is latched.
  - Changes on tx_data after acceptance do not affect the frame.
  - The source must hold valid until it sees ready; valid may stay high for back-to-back bytes.
- Bit timing:
  - Every bit period lasts exactly CYCLE clocks.
  - cycle_cnt counts 0..CYCLE-1. It wraps to 0 at CYCLE-1 and on every state change.
- S_START: tx_pin = 0. At cycle_cnt == CYCLE-1, go to S_SEND_BYTE, drive tx_pin = data[0], bit_cnt = 0.
- S_SEND_BYTE:
  - tx_pin = data[bit_cnt].
  - At cycle_cnt == CYCLE-1 with bit_cnt < 7: bit_cnt increments and tx_pin takes the next bit.
  - At cycle_cnt == CYCLE-1 with bit_cnt == 7: bit_cnt wraps to 0.
    - If PARITY is 1 or 2, go to S_PARITY.
    - Otherwise go to S_STOP.
- S_PARITY:
  - tx_pin = ^data for even parity, ~^data for odd parity.
  - At cycle_cnt == CYCLE-1, go to S_STOP.
- S_STOP:
  - tx_pin = 1 for STOP_BITS*CYCLE clocks; the stop-bit index is tracked with bit_cnt.
  - Then return to S_IDLE with tx_pin held at 1.
- Frame spacing:
  - S_IDLE lasts at least one clock. The minimum gap between frames is therefore STOP_BITS*CYCLE + 1 clocks of mark.
  - Total line time per byte = (1 + 8 + P + STOP_BITS)*CYCLE clocks, where P = 1 if parity is enabled, else 0.
- Widths:
  - cycle_cnt is 16 bits, so CYCLE must be <= 65535.
  - bit_cnt is 3 bits.
- tx_pin is glitch-free: registered only, with no combinational path to the pin.

Test Plan:
- Default params, send 0x55 after reset:
  - tx_pin = 1 until acceptance.
  - Then 0,1,0,1,0,1,0,1,0,1, each bit 434 clocks.
  - tx_data_ready low for exactly 4340 clocks, then high.
- Back-to-back: tx_data_valid held high with 0x00 then 0xFF.
  - Second acceptance occurs exactly 4341 clocks after the first.
  - Second frame is 0, eight 1s, 1.
  - tx_data changed to 0x12 mid-frame does not alter the bits sent.
- PARITY=2 with 0xA5 gives parity bit 0; PARITY=1 with 0xA5 gives parity bit 1; PARITY=2 with 0x01 gives parity bit 1.
  - Frame length is 11*434 clocks in each case.
- STOP_BITS=2, send 0x80:
  - Stop level 1 held for 868 clocks.
  - Next acceptance no earlier than 869 clocks after the last data bit ends.
- Reset mid-frame: assert rst_n low during data bit 3.
  - tx_pin = 1 immediately; tx_data_ready = 1; tx_busy = 0.
  - After release, a new byte 0x3C transmits correctly.
- Loopback: tx_pin drives the existing UART receiver (same CLK_FRE/BAUD_RATE, 8N1).
  - 256 random bytes are sent; all are received in order.
